// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the modulo-1000 counter sequencer.
package counter_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin
   } state_e;

   localparam int unsigned DEF_WIDTH   = 10;
   localparam int unsigned DEF_MAX_VAL = 999;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command sequencer driving a modulo-(MAX_VAL+1) up/down counter for N steps.
// Optional COUNTER_SEQ_CTRL_PAUSE_EN adds a pause input that freezes stepping.
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_steps,
   input  logic             abort,
`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_mode,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             wrap
);

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             aborted_q, aborted_d;
   logic             wrap_q, wrap_d;

   logic pause_act;
   logic running;
   logic step;
   logic at_max;
   logic at_zero;

`ifdef COUNTER_SEQ_CTRL_PAUSE_EN
   assign pause_act = pause;
`else
   assign pause_act = 1'b0;
`endif

   assign running = (state_q == StRun);
   assign step    = running && !abort && !pause_act;
   assign at_max  = (cnt_value == WIDTH'(MAX_VAL));
   assign at_zero = (cnt_value == '0);

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      remaining_d = remaining_q;
      aborted_d   = 1'b0;
      // Wrap is judged on the value the counter holds before this step lands.
      wrap_d      = step && (((dir_q == DIR_UP) && at_max) ||
                             ((dir_q == DIR_DOWN) && at_zero));

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               dir_d       = cmd_dir;
               remaining_d = cmd_steps;
               state_d     = (cmd_steps == '0) ? StFin : StRun;
            end
         end
         StRun: begin
            if (abort) begin
               aborted_d   = 1'b1;
               remaining_d = '0;
               state_d     = StIdle;
            end else if (!pause_act) begin
               if (remaining_q == WIDTH'(1)) begin
                  state_d = StFin;
               end
               remaining_d = remaining_q - WIDTH'(1);
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         dir_q       <= DIR_DOWN;
         remaining_q <= '0;
         aborted_q   <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         remaining_q <= remaining_d;
         aborted_q   <= aborted_d;
         wrap_q      <= wrap_d;
      end
   end

   assign cmd_ready = (state_q == StIdle) && !rst;
   assign cnt_en    = step;
   assign cnt_mode  = running ? dir_q : DIR_DOWN;
   assign busy      = running;
   assign done      = (state_q == StFin);
   assign aborted   = aborted_q;
   assign wrap      = wrap_q;

endmodule
